// File: rtl/lenet_pkg.sv
// Shared LeNet-5 geometry, buffer strides, requant widths and the conv FSM state type.
// Imported by the Conv2 layer and the reusable requant stage.
package lenet_pkg;

   localparam int C1_CH   = 6;
   localparam int P1_DIM  = 14;
   localparam int C2_FILT = 16;
   localparam int C2_K    = 5;
   localparam int C2_DIM  = 10;
   localparam int C2_TAPS = 150;

   localparam int P1_CH_STRIDE  = 196;
   localparam int C2_OUT_STRIDE = 100;
   localparam int W_FILT_STRIDE = 150;

   localparam int ACC_W  = 32;
   localparam int MULT_W = 16;
   localparam int PROD_W = 48;
   localparam int Q_W    = 8;

   localparam int IN_AW  = 11;
   localparam int W_AW   = 12;
   localparam int B_AW   = 4;
   localparam int OUT_AW = 11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_BIAS    = 3'd1,
      ST_MAC     = 3'd2,
      ST_REQUANT = 3'd3,
      ST_WRITE   = 3'd4,
      ST_DONE    = 3'd5
   } conv_state_t;

endpackage

// File: rtl/lenet_requant.sv
// Combinational int32 -> int8 requantiser: multiply, floor shift, clamp.
// Build option CONV2_RELU_EN fuses a ReLU (0..127); otherwise signed saturation (-128..127).
module lenet_requant
   import lenet_pkg::*;
#(
   parameter logic signed [MULT_W-1:0] QUANT_MULT  = 16'sd1,
   parameter int                       QUANT_SHIFT = 8
)
(
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [Q_W-1:0]   q
);

   logic signed [PROD_W-1:0] acc_x;
   logic signed [PROD_W-1:0] mult_x;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] shifted;

   always_comb begin
      acc_x   = {{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc};
      mult_x  = {{(PROD_W-MULT_W){QUANT_MULT[MULT_W-1]}}, QUANT_MULT};
      prod    = acc_x * mult_x;
      // Arithmetic shift on a signed operand floors toward minus infinity.
      shifted = prod >>> QUANT_SHIFT;
`ifdef CONV2_RELU_EN
      if (shifted < 48'sd0)
         q = 8'sd0;
      else if (shifted > 48'sd127)
         q = 8'sd127;
      else
         q = shifted[Q_W-1:0];
`else
      if (shifted > 48'sd127)
         q = 8'sd127;
      else if (shifted < -48'sd128)
         q = -8'sd128;
      else
         q = shifted[Q_W-1:0];
`endif
   end

endmodule

// File: rtl/lenet_conv2_layer.sv
// LeNet-5 Conv2: 16 filters of 5x5x6 over the 6x14x14 Pool1 map, one MAC tap per cycle.
// Output clamp selected by CONV2_RELU_EN (see lenet_requant); timing is identical in both builds.
module lenet_conv2_layer
   import lenet_pkg::*;
#(
   parameter logic signed [MULT_W-1:0] QUANT_MULT  = 16'sd1,
   parameter int                       QUANT_SHIFT = 8,
   parameter int                       NUM_FILT    = C2_FILT
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [IN_AW-1:0]         in_addr,
   input  logic signed [Q_W-1:0]    in_data,
   output logic [W_AW-1:0]          w_addr,
   input  logic signed [Q_W-1:0]    w_data,
   output logic [B_AW-1:0]          b_addr,
   input  logic signed [ACC_W-1:0]  b_data,
   output logic [OUT_AW-1:0]        out_addr,
   output logic signed [Q_W-1:0]    out_data,
   output logic                     out_wr_en,
   output conv_state_t              dbg_state
);

   localparam logic [2:0] C_LAST = 3'(C1_CH - 1);
   localparam logic [2:0] K_LAST = 3'(C2_K - 1);
   localparam logic [3:0] D_LAST = 4'(C2_DIM - 1);
   localparam logic [3:0] F_LAST = 4'(NUM_FILT - 1);

   conv_state_t state, state_n;
   logic [3:0] f, r, col, f_n, r_n, col_n;
   logic [2:0] c, kr, kc, c_n, kr_n, kc_n;
   logic signed [ACC_W-1:0]  acc;
   logic signed [15:0]       prod16;
   logic signed [ACC_W-1:0]  prod32;
   logic signed [Q_W-1:0]    q_val;
   logic [IN_AW-1:0]         in_addr_n;
   logic [W_AW-1:0]          w_addr_n;
   logic [OUT_AW-1:0]        out_addr_n;
   logic                     tap_last, pos_last;

   assign tap_last  = (c == C_LAST) && (kr == K_LAST) && (kc == K_LAST);
   assign pos_last  = (f == F_LAST) && (r == D_LAST) && (col == D_LAST);
   assign b_addr    = f;
   assign dbg_state = state;

   assign prod16 = in_data * w_data;
   assign prod32 = {{16{prod16[15]}}, prod16};

   lenet_requant #(
      .QUANT_MULT  (QUANT_MULT),
      .QUANT_SHIFT (QUANT_SHIFT)
   ) u_requant (
      .acc (acc),
      .q   (q_val)
   );

   always_comb begin
      state_n = state;
      f_n     = f;
      r_n     = r;
      col_n   = col;
      c_n     = c;
      kr_n    = kr;
      kc_n    = kc;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_BIAS;
               f_n     = 4'd0;
               r_n     = 4'd0;
               col_n   = 4'd0;
               c_n     = 3'd0;
               kr_n    = 3'd0;
               kc_n    = 3'd0;
            end
         end
         ST_BIAS: state_n = ST_MAC;
         ST_MAC: begin
            if (tap_last)
               state_n = ST_REQUANT;
            // kc fastest, then kr, then c; wraps back to tap 0 after the last tap
            if (kc == K_LAST) begin
               kc_n = 3'd0;
               if (kr == K_LAST) begin
                  kr_n = 3'd0;
                  c_n  = (c == C_LAST) ? 3'd0 : c + 3'd1;
               end else begin
                  kr_n = kr + 3'd1;
               end
            end else begin
               kc_n = kc + 3'd1;
            end
         end
         ST_REQUANT: state_n = ST_WRITE;
         ST_WRITE: begin
            c_n  = 3'd0;
            kr_n = 3'd0;
            kc_n = 3'd0;
            if (col == D_LAST) begin
               col_n = 4'd0;
               if (r == D_LAST) begin
                  r_n = 4'd0;
                  f_n = pos_last ? 4'd0 : f + 4'd1;
               end else begin
                  r_n = r + 4'd1;
               end
            end else begin
               col_n = col + 4'd1;
            end
            state_n = pos_last ? ST_DONE : ST_BIAS;
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase

      // Addresses are registered from the next counters so they line up with the next tap.
      in_addr_n  = IN_AW'(int'(c_n) * P1_CH_STRIDE + (int'(r_n) + int'(kr_n)) * P1_DIM
                          + int'(col_n) + int'(kc_n));
      w_addr_n   = W_AW'(int'(f_n) * W_FILT_STRIDE + int'(c_n) * (C2_K * C2_K)
                         + int'(kr_n) * C2_K + int'(kc_n));
      out_addr_n = OUT_AW'(int'(f) * C2_OUT_STRIDE + int'(r) * C2_DIM + int'(col));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         f         <= 4'd0;
         r         <= 4'd0;
         col       <= 4'd0;
         c         <= 3'd0;
         kr        <= 3'd0;
         kc        <= 3'd0;
         acc       <= '0;
         in_addr   <= '0;
         w_addr    <= '0;
         out_addr  <= '0;
         out_data  <= '0;
         out_wr_en <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state   <= state_n;
         f       <= f_n;
         r       <= r_n;
         col     <= col_n;
         c       <= c_n;
         kr      <= kr_n;
         kc      <= kc_n;
         in_addr <= in_addr_n;
         w_addr  <= w_addr_n;
         if (state == ST_BIAS)
            acc <= b_data;
         else if (state == ST_MAC)
            acc <= acc + prod32;
         if (state == ST_REQUANT) begin
            out_data <= q_val;
            out_addr <= out_addr_n;
         end
         out_wr_en <= (state_n == ST_WRITE);
         done      <= (state_n == ST_DONE);
         busy      <= (state_n == ST_BIAS) || (state_n == ST_MAC) ||
                      (state_n == ST_REQUANT) || (state_n == ST_WRITE);
      end
   end

endmodule

// File: tb/tb_lenet_conv2_layer.sv
// Directed bench for lenet_conv2_layer, built with two filters to keep full runs short.
// Buffers are modelled as arrays; writes are captured on the falling edge.
`timescale 1ns/1ps
module tb_lenet_conv2_layer;
   import lenet_pkg::*;

   localparam int NF      = 2;
   localparam int N_OUT   = NF * C2_OUT_STRIDE;
   localparam int RUN_CYC = N_OUT * 153 + 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                busy, done, out_wr_en;
   logic [10:0]         in_addr, out_addr;
   logic [11:0]         w_addr;
   logic [3:0]          b_addr;
   logic signed [7:0]   in_data, w_data, out_data;
   logic signed [31:0]  b_data;
   conv_state_t         dbg_state;

   logic signed [7:0]   in_mem  [0:1175];
   logic signed [7:0]   w_mem   [0:2399];
   logic signed [31:0]  b_mem   [0:15];
   logic signed [7:0]   out_mem [0:1599];

   int errors = 0;
   int checks = 0;
   int wr_count = 0;
   int done_count = 0;
   int bad_wr = 0;

   always #5 clk = ~clk;

   lenet_conv2_layer #(
      .QUANT_MULT  (16'sd1),
      .QUANT_SHIFT (8),
      .NUM_FILT    (NF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_wr_en (out_wr_en),
      .dbg_state (dbg_state)
   );

   assign in_data = (in_addr < 11'd1176) ? in_mem[in_addr] : 8'sd0;
   assign w_data  = (w_addr < 12'd2400) ? w_mem[w_addr] : 8'sd0;
   assign b_data  = b_mem[b_addr];

   always @(negedge clk) begin
      if (out_wr_en === 1'b1) begin
         wr_count++;
         if (out_addr < 11'd1600)
            out_mem[out_addr] = out_data;
         if (dbg_state !== ST_WRITE)
            bad_wr++;
      end
      if (done === 1'b1)
         done_count++;
   end

   task automatic clear_mems();
      for (int i = 0; i < 1176; i++) in_mem[i] = 8'sd0;
      for (int i = 0; i < 2400; i++) w_mem[i] = 8'sd0;
      for (int i = 0; i < 16; i++) b_mem[i] = 32'sd0;
      for (int i = 0; i < 1600; i++) out_mem[i] = 8'sh55;
   endtask

   task automatic do_reset();
      start = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget, output bit ok);
      int target;
      int k;
      target = wr_count + n;
      k = 0;
      while (wr_count < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = (wr_count >= target);
   endtask

   task automatic test_reset();
      clear_mems();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", out_wr_en); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      checks++; if (in_addr !== 11'd0 || w_addr !== 12'd0) begin errors++; $display("FAIL reset_rd_addr got=%0d/%0d exp=0/0", in_addr, w_addr); end
      checks++; if (out_addr !== 11'd0 || out_data !== 8'sd0) begin errors++; $display("FAIL reset_out got=%0d/%0d exp=0/0", out_addr, out_data); end
      checks++; if (b_addr !== 4'd0) begin errors++; $display("FAIL reset_b_addr got=%0d exp=0", b_addr); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Weights 0, bias[f] = f*256, shift 8: each output equals its filter index.
   task automatic test_bias_only();
      int n, first_wr, done_at, wr0, dn0, nbad, first_bad;
      clear_mems();
      for (int i = 0; i < 16; i++) b_mem[i] = 32'(i * 256);
      wr0 = wr_count;
      dn0 = done_count;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      first_wr = 0;
      done_at = 0;
      while (done_at == 0 && n < RUN_CYC + 50) begin
         if (out_wr_en === 1'b1 && first_wr == 0) first_wr = n;
         if (done === 1'b1) done_at = n;
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++; if (first_wr != 153) begin errors++; $display("FAIL first_write_latency got=%0d exp=153", first_wr); end
      checks++; if (done_at != RUN_CYC) begin errors++; $display("FAIL done_latency got=%0d exp=%0d", done_at, RUN_CYC); end
      checks++; if (wr_count - wr0 != N_OUT) begin errors++; $display("FAIL bias_write_count got=%0d exp=%0d", wr_count - wr0, N_OUT); end
      checks++; if (done_count - dn0 != 1) begin errors++; $display("FAIL bias_done_pulses got=%0d exp=1", done_count - dn0); end
      checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL bias_end_idle got=busy %b state %0d exp=busy 0 state 0", busy, dbg_state); end
      nbad = 0;
      first_bad = -1;
      for (int k = 0; k < N_OUT; k++)
         if (out_mem[k] !== 8'(k / 100)) begin
            nbad++;
            if (first_bad < 0) first_bad = k;
         end
      checks++; if (nbad != 0) begin errors++; $display("FAIL bias_outputs got=%0d bad (first idx %0d) exp=0 bad", nbad, first_bad); end
      checks++; if (bad_wr != 0) begin errors++; $display("FAIL wr_en_outside_write got=%0d exp=0", bad_wr); end
   endtask

   // First output only: uniform input/weight and bias on filter 0 exercise floor and clamp.
   task automatic test_clamp();
      logic signed [7:0]  cv_in   [10] = '{8'sd1, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, -8'sd2, -8'sd128};
      logic signed [7:0]  cv_w    [10] = '{8'sd1, -8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd3, 8'sd127};
      logic signed [31:0] cv_b    [10] = '{32'sd40000, -32'sd40000, 32'sd32767, 32'sd32768, -32'sd32768,
                                           -32'sd32769, -32'sd300, 32'sd300, 32'sd0, 32'sd2439680};
      logic signed [7:0]  cv_raw  [10] = '{8'sd127, -8'sd128, 8'sd127, 8'sd127, -8'sd128, -8'sd128, -8'sd2, 8'sd1, -8'sd4, 8'sd5};
      logic signed [7:0]  cv_relu [10] = '{8'sd127, 8'sd0, 8'sd127, 8'sd127, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd5};
      logic signed [7:0]  exp_v;
      bit ok;
      for (int t = 0; t < 10; t++) begin
         do_reset();
         clear_mems();
         for (int i = 0; i < 1176; i++) in_mem[i] = cv_in[t];
         for (int i = 0; i < 150; i++) w_mem[i] = cv_w[t];
         b_mem[0] = cv_b[t];
`ifdef CONV2_RELU_EN
         exp_v = cv_relu[t];
`else
         exp_v = cv_raw[t];
`endif
         pulse_start();
         wait_writes(1, 400, ok);
         @(negedge clk);
         checks++;
         if (!ok || out_mem[0] !== exp_v) begin
            errors++;
            $display("FAIL clamp[%0d] got=%0d (written %0d) exp=%0d", t, out_mem[0], ok, exp_v);
         end
      end
      do_reset();
   endtask

   // One nonzero tap lands on filter 1 row 2 col 2; start is re-pulsed while busy.
   task automatic test_single_tap_and_restart();
      int wr0, dn0, nbad, first_bad, k;
      logic signed [7:0] exp_v;
      clear_mems();
      for (int i = 0; i < 16; i++) b_mem[i] = 32'(i * 256);
      in_mem[438] = 8'sd100;
      w_mem[207]  = 8'sd64;
      wr0 = wr_count;
      dn0 = done_count;
      repeat (10) @(negedge clk);
      pulse_start();
      repeat (489) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", busy); end
      pulse_start();
      k = 0;
      while (done_count == dn0 && k < RUN_CYC + 100) begin
         @(negedge clk);
         k++;
      end
      repeat (300) @(negedge clk);
      checks++; if (done_count - dn0 != 1) begin errors++; $display("FAIL restart_done_pulses got=%0d exp=1", done_count - dn0); end
      checks++; if (wr_count - wr0 != N_OUT) begin errors++; $display("FAIL restart_write_count got=%0d exp=%0d", wr_count - wr0, N_OUT); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL restart_idle got=%0d exp=0", dbg_state); end
      checks++; if (out_mem[122] !== 8'sd26) begin errors++; $display("FAIL single_tap_hit got=%0d exp=26", out_mem[122]); end
      nbad = 0;
      first_bad = -1;
      for (int i = 0; i < N_OUT; i++) begin
         exp_v = (i == 122) ? 8'sd26 : 8'(i / 100);
         if (out_mem[i] !== exp_v) begin
            nbad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      checks++; if (nbad != 0) begin errors++; $display("FAIL single_tap_all got=%0d bad (first idx %0d) exp=0 bad", nbad, first_bad); end
   endtask

   // Abort mid-run with rst_n, confirm silence, then restart and check the first outputs.
   task automatic test_reset_abort();
      int wr0, wr_hold, nbad;
      bit ok;
      clear_mems();
      for (int y = 0; y < 14; y++)
         for (int x = 0; x < 8; x++)
            in_mem[y * 14 + x] = 8'(x * 16);
      w_mem[0] = 8'sd16;
      wr0 = wr_count;
      pulse_start();
      repeat (4999) @(negedge clk);
      checks++; if (wr_count - wr0 != 32) begin errors++; $display("FAIL abort_pre_writes got=%0d exp=32", wr_count - wr0); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || out_wr_en !== 1'b0) begin errors++; $display("FAIL abort_async got=busy %b wr %b exp=0 0", busy, out_wr_en); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
      wr_hold = wr_count;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      checks++; if (wr_count != wr_hold) begin errors++; $display("FAIL abort_spurious got=%0d writes exp=0", wr_count - wr_hold); end
      for (int i = 0; i < 1600; i++) out_mem[i] = 8'sh55;
      pulse_start();
      wait_writes(5, 5 * 153 + 50, ok);
      @(negedge clk);
      nbad = 0;
      for (int i = 0; i < 5; i++)
         if (out_mem[i] !== 8'(i)) nbad++;
      checks++; if (!ok || nbad != 0) begin errors++; $display("FAIL abort_rerun got=%0d bad (written %0d) exp=0 bad", nbad, ok); end
      do_reset();
      checks++; if (bad_wr != 0) begin errors++; $display("FAIL wr_en_outside_write_final got=%0d exp=0", bad_wr); end
   endtask

   initial begin
      test_reset();
      test_bias_only();
      test_clamp();
      test_single_tap_and_restart();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
